t_pulse_gen: RTL and testbench

Programmable toggle-strobe generator that drives the `t` enable input of the downstream two-stage toggle divider. On a `start` request, it emits single-cycle `t` pulses at a programmed period. It emits either a fixed burst of pulses or runs continuously until `stop`, and reports `busy`, `done` and a running pulse count. Both stages share one clock domain.

---
 rtl/t_pulse_gen_pkg.sv | 12 +
 rtl/tpg_sync2.sv | 21 ++
 rtl/t_pulse_gen.sv | 106 ++++++++++
 tb/tb_t_pulse_gen.sv | 128 ++++++++++++
 4 files changed

// File: rtl/t_pulse_gen_pkg.sv
// Shared types and defaults for the t_pulse_gen toggle-strobe generator.
package t_pulse_gen_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tpg_sync2.sv
// Single-bit two-flop synchronizer with synchronous active-high reset to 0.
module tpg_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/t_pulse_gen.sv
// Programmable toggle-strobe generator: burst or continuous single-cycle t pulses.
// Define TPG_START_SYNC_EN to pass start/stop through two-flop synchronizers (+2 cycles).
module t_pulse_gen
  import t_pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] burst,
  output logic             t,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  logic start_s;
  logic stop_s;

`ifdef TPG_START_SYNC_EN
  tpg_sync2 u_sync_start (.clk(clk), .rst(rst), .d(start), .q(start_s));
  tpg_sync2 u_sync_stop  (.clk(clk), .rst(rst), .d(stop),  .q(stop_s));
`else
  assign start_s = start;
  assign stop_s  = stop;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] pcnt, pcnt_nxt;
  logic [CNT_W-1:0] per_sh, per_sh_nxt;
  logic [CNT_W-1:0] burst_sh, burst_sh_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             t_nxt, busy_nxt, done_nxt;
  logic             last;

  // The pulse on t right now is the final one of a finite burst.
  assign last = t && (burst_sh != '0) && (count == burst_sh);

  always_comb begin
    state_nxt    = state;
    pcnt_nxt     = pcnt;
    per_sh_nxt   = per_sh;
    burst_sh_nxt = burst_sh;
    count_nxt    = count;
    t_nxt        = 1'b0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start_s && !stop_s && (period != '0)) begin
          state_nxt    = RUN;
          per_sh_nxt   = period;
          burst_sh_nxt = burst;
          count_nxt    = '0;
          pcnt_nxt     = period - CNT_W'(1);
        end
      end
      RUN: begin
        // Stop outranks both burst completion and a due pulse.
        if (stop_s) begin
          state_nxt = IDLE;
        end else if (last) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          busy_nxt = 1'b1;
          if (pcnt == '0) begin
            t_nxt     = 1'b1;
            count_nxt = count + CNT_W'(1);
            pcnt_nxt  = per_sh - CNT_W'(1);
          end else begin
            pcnt_nxt = pcnt - CNT_W'(1);
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pcnt     <= '0;
      per_sh   <= '0;
      burst_sh <= '0;
      count    <= '0;
      t        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pcnt     <= pcnt_nxt;
      per_sh   <= per_sh_nxt;
      burst_sh <= burst_sh_nxt;
      count    <= count_nxt;
      t        <= t_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_t_pulse_gen.sv
// Scoreboard bench for t_pulse_gen: expected outputs derived from the timing rules.
module tb_t_pulse_gen;

  localparam int CW = 16;
`ifdef TPG_START_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, stop;
  logic [CW-1:0] period, burst;
  logic          t, busy, done;
  logic [CW-1:0] count;

  t_pulse_gen #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .period(period), .burst(burst),
    .t(t), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit t;
    bit busy;
    bit done;
    int count;
  } exp_s;

  exp_s sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   last_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outputs after relative edge k (start driven for edge 0).
  function automatic exp_s model(int k, int P, int B, int S, int R, bit ign, int c0);
    exp_s e;
    int   se, m;
    e = '{t: 1'b0, busy: 1'b0, done: 1'b0, count: c0};
    if (R >= 0 && k >= R) begin
      e.count = 0;
      return e;
    end
    if (ign || k < L) return e;
    e.count = 0;
    if (k == L) return e;
    se = (S >= 0) ? S + L : (1 << 30);
    m  = (B > 0) ? L + B * P : (1 << 30);
    if (k >= se && se <= m + 1) begin
      e.count = (se - 1 - L) / P;
    end else if (k <= m) begin
      e.busy  = 1'b1;
      e.t     = ((k - L) % P) == 0;
      e.count = (k - L) / P;
    end else begin
      e.count = B;
      e.done  = (k == m + 1);
    end
    return e;
  endfunction

  task automatic run_scn(input string nm, input int P, input int B, input int S, input int R,
                         input int X, input int chg, input int newp, input bit ign,
                         input bit both, input int n);
    exp_s e;
    for (int k = 0; k < n; k++) begin
      start  = (k == 0) || (k == X);
      stop   = (k == S) || (both && k == 0);
      period = CW'((chg >= 0 && k >= chg) ? newp : P);
      burst  = CW'(B);
      rst    = (R >= 0 && k == R);
      sb.push_back(model(k, P, B, S, R, ign, last_cnt));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({nm, ".t"},     32'(t),     32'(e.t));
      chk({nm, ".busy"},  32'(busy),  32'(e.busy));
      chk({nm, ".done"},  32'(done),  32'(e.done));
      chk({nm, ".count"}, 32'(count), 32'(e.count));
    end
    last_cnt = model(n - 1, P, B, S, R, ign, last_cnt).count;
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    stop   = 1'b0;
    period = CW'(4);
    burst  = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("reset.t",     32'(t),     32'd0);
      chk("reset.busy",  32'(busy),  32'd0);
      chk("reset.done",  32'(done),  32'd0);
      chk("reset.count", 32'(count), 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_scn("burst",      4, 3, -1, -1, -1, -1,    0, 1'b0, 1'b0, 30);
    run_scn("cont_stop",  1, 0,  6, -1, -1, -1,    0, 1'b0, 1'b0, 14);
    run_scn("period0",    0, 3, -1, -1, -1, -1,    0, 1'b1, 1'b0, 6);
    run_scn("start_stop", 4, 2, -1, -1, -1, -1,    0, 1'b1, 1'b1, 6);
    run_scn("restart",    3, 4, -1, -1,  5, -1,    0, 1'b0, 1'b0, 20);
    run_scn("shadow",     4, 3, -1, -1, -1, L + 1, 2, 1'b0, 1'b0, 20);
    run_scn("rst_mid",    2, 0, -1,  7, -1, -1,    0, 1'b0, 1'b0, 12);
    run_scn("fast",       1, 2, -1, -1, -1, -1,    0, 1'b0, 1'b0, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
